// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared display package: default scan timing, slot encoding, shadow layout
// and the active-low seven-segment glyph table ({g,f,e,d,c,b,a}).
package ssd_scan_ctrl_pkg;

  localparam int unsigned DEF_REFRESH_DIV  = 50000;
  localparam int unsigned DEF_BLANK_CYC    = 16;
  localparam int unsigned DEF_BLINK_FRAMES = 250;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic [1:0] {
    SLOT_0 = 2'd0,
    SLOT_1 = 2'd1,
    SLOT_2 = 2'd2,
    SLOT_3 = 2'd3
  } slot_e;

  // Frame-stable copy of the display inputs.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  blink_en;
    logic [3:0]  dp_in;
  } shadow_t;

  // Hex glyphs 0-9, A, b, C, d, E, F; a cleared bit lights the segment.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/ssd_scan_ctrl_hex_decode.sv
// Combinational nibble-to-glyph decoder for an active-low 7-segment digit.
module ssd_hex_decode
  import ssd_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Table lookup; every 4-bit code has a defined glyph.
  always_comb begin
    glyph = GLYPH_TABLE[nibble];
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with per-frame input
// shadowing, anti-ghosting blank window, per-digit blink and decimal points.
module ssd_scan_ctrl
  import ssd_scan_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int unsigned BLANK_CYC    = DEF_BLANK_CYC,
  parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  blink_en,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_r;
  slot_e            sel_r;
  logic [FRM_W-1:0] frm_cnt_r;
  logic             blink_phase_r;
  shadow_t          shadow_r;
  logic             frame_start_r;
  logic [6:0]       seg_r;
  logic [3:0]       an_r;
  logic             dp_r;

  logic             tick_s;
  logic             frame_tick_s;
  logic [3:0]       nibble_s;
  logic [6:0]       glyph_s;
  logic             visible_s;
  logic             blank_s;
  logic [6:0]       seg_nxt_s;
  logic [3:0]       an_nxt_s;
  logic             dp_nxt_s;

  assign tick_s       = (cnt_r == CNT_LAST);
  assign frame_tick_s = tick_s && (sel_r == SLOT_3);

  // Prescaler: one digit slot every REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Slot select walks 0,1,2,3 on each prescaler tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_r <= SLOT_0;
    end else if (tick_s) begin
      sel_r <= slot_e'(sel_r + 2'd1);
    end else begin
      sel_r <= sel_r;
    end
  end

  // Shadow load at the end of slot 3 so a whole frame sees one snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_r      <= '0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= frame_tick_s;
      if (frame_tick_s) begin
        shadow_r <= '{value: value, digit_en: digit_en,
                      blink_en: blink_en, dp_in: dp_in};
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

  // Frame counter flips the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm_cnt_r     <= '0;
      blink_phase_r <= 1'b0;
    end else if (frame_tick_s) begin
      if (frm_cnt_r == FRM_LAST) begin
        frm_cnt_r     <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frm_cnt_r     <= frm_cnt_r + FRM_W'(1);
        blink_phase_r <= blink_phase_r;
      end
    end else begin
      frm_cnt_r     <= frm_cnt_r;
      blink_phase_r <= blink_phase_r;
    end
  end

  // Pick the selected digit's nibble out of the shadow value.
  always_comb begin
    nibble_s = 4'h0;
    case (sel_r)
      SLOT_0:  nibble_s = shadow_r.value[3:0];
      SLOT_1:  nibble_s = shadow_r.value[7:4];
      SLOT_2:  nibble_s = shadow_r.value[11:8];
      SLOT_3:  nibble_s = shadow_r.value[15:12];
      default: nibble_s = 4'h0;
    endcase
  end

  ssd_hex_decode u_hex_decode (
    .nibble (nibble_s),
    .glyph  (glyph_s)
  );

  // Next display drive: blank during the guard window or for dark digits.
  always_comb begin
    visible_s = shadow_r.digit_en[sel_r] &
                ~(blink_phase_r & shadow_r.blink_en[sel_r]);
    blank_s   = (cnt_r < CNT_BLANK) | ~visible_s;
    an_nxt_s  = AN_OFF;
    seg_nxt_s = SEG_BLANK;
    dp_nxt_s  = 1'b1;
    if (blank_s) begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_BLANK;
      dp_nxt_s  = 1'b1;
    end else begin
      an_nxt_s  = ~(4'b0001 << sel_r);
      seg_nxt_s = glyph_s;
      dp_nxt_s  = ~shadow_r.dp_in[sel_r];
    end
  end

  // Output registers give glitch-free pins with one cycle of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
    end
  end

  assign an          = an_r;
  assign seg         = seg_r;
  assign dp          = dp_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with a small slot/blink reference model.
module tb_ssd_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  digit_en = 4'h0;
  logic [3:0]  blink_en = 4'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  // Reference shadow, frame counter and blink phase.
  logic [15:0] m_val;
  logic [3:0]  m_en, m_blink, m_dp;
  int          m_frm;
  logic        m_phase;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .digit_en    (digit_en),
    .blink_en    (blink_en),
    .dp_in       (dp_in),
    .seg         (seg),
    .an          (an),
    .dp          (dp),
    .frame_start (frame_start)
  );

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'h7F;
    endcase
  endfunction

  task automatic model_clear();
    m_val = 16'h0000; m_en = 4'h0; m_blink = 4'h0; m_dp = 4'h0;
    m_frm = 0; m_phase = 1'b0;
  endtask

  task automatic model_load();
    m_val = value; m_en = digit_en; m_blink = blink_en; m_dp = dp_in;
    if (m_frm == BF - 1) begin
      m_frm = 0;
      m_phase = ~m_phase;
    end else begin
      m_frm = m_frm + 1;
    end
  endtask

  // Release reset and expect a blank display until frame_start after 32 edges.
  task automatic release_and_wait_first(input string tag);
    int first;
    first = 0;
    model_clear();
    rst = 1'b1;
    for (int k = 1; k <= FRAME + 8; k++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        first = k;
        break;
      end
      n_cmp++;
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        n_err++;
        $display("FAIL %s_blank k=%0d got an=%h seg=%h dp=%b want an=f seg=7f dp=1",
                 tag, k, an, seg, dp);
      end
    end
    n_cmp++;
    if (first !== FRAME) begin
      n_err++;
      $display("FAIL %s_first_frame_start got cycle %0d want %0d", tag, first, FRAME);
    end
    model_load();
  endtask

  // Check one full frame starting right after an observed frame_start.
  task automatic run_frame(input string tag, input bit do_mid, input logic [15:0] mid_val);
    int s, sl, c;
    logic vis;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fs;
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      s  = j - 1;
      sl = s / RD;
      c  = s % RD;
      vis = m_en[sl] && !(m_phase && m_blink[sl]);
      if (c < BC || !vis) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an = 4'(~(4'b0001 << sl)); e_seg = glyph(m_val[sl*4 +: 4]); e_dp = ~m_dp[sl];
      end
      e_fs = (j == FRAME);
      n_cmp++;
      if (an !== e_an) begin
        n_err++;
        $display("FAIL %s_an j=%0d got %h want %h", tag, j, an, e_an);
      end
      n_cmp++;
      if (seg !== e_seg) begin
        n_err++;
        $display("FAIL %s_seg j=%0d got %b want %b", tag, j, seg, e_seg);
      end
      n_cmp++;
      if (dp !== e_dp) begin
        n_err++;
        $display("FAIL %s_dp j=%0d got %b want %b", tag, j, dp, e_dp);
      end
      n_cmp++;
      if (frame_start !== e_fs) begin
        n_err++;
        $display("FAIL %s_frame_start j=%0d got %b want %b", tag, j, frame_start, e_fs);
      end
      if (do_mid && j == 20) value = mid_val;
    end
    model_load();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    value = 16'h1208; digit_en = 4'hF; blink_en = 4'h0; dp_in = 4'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_hold got an=%h seg=%h dp=%b fs=%b want f 7f 1 0",
               an, seg, dp, frame_start);
    end
    release_and_wait_first("reset");
  endtask

  task automatic test_decode();
    run_frame("decode_f1", 1'b0, 16'h0000);
    run_frame("decode_f2", 1'b0, 16'h0000);
  endtask

  task automatic test_no_tear();
    value = 16'h1111;
    run_frame("tear_pre", 1'b0, 16'h0000);
    run_frame("tear_mid", 1'b1, 16'h2222);
    run_frame("tear_post", 1'b0, 16'h0000);
  endtask

  task automatic test_dark_digits();
    value = 16'h4567; digit_en = 4'b0011;
    run_frame("dark_pre", 1'b0, 16'h0000);
    run_frame("dark_f1", 1'b0, 16'h0000);
    run_frame("dark_f2", 1'b0, 16'h0000);
  endtask

  task automatic test_blink();
    value = 16'h89AB; digit_en = 4'hF; blink_en = 4'b0001;
    for (int f = 0; f < 7; f++) run_frame($sformatf("blink_f%0d", f), 1'b0, 16'h0000);
  endtask

  task automatic test_dp();
    value = 16'hCDEF; blink_en = 4'h0; dp_in = 4'b0100;
    run_frame("dp_pre", 1'b0, 16'h0000);
    run_frame("dp_f1", 1'b0, 16'h0000);
    run_frame("dp_f2", 1'b0, 16'h0000);
  endtask

  task automatic test_async_reset();
    repeat (14) @(negedge clk);
    n_cmp++;
    if (an !== 4'b1101) begin
      n_err++;
      $display("FAIL areset_pre_an got %h want d", an);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL areset_blank got an=%h seg=%h dp=%b fs=%b want f 7f 1 0",
               an, seg, dp, frame_start);
    end
    @(negedge clk);
    value = 16'h0A3F; digit_en = 4'hF; blink_en = 4'h0; dp_in = 4'b0001;
    release_and_wait_first("areset");
    run_frame("areset_f1", 1'b0, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_no_tear();
    test_dark_digits();
    test_blink();
    test_dp();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
